adc_rx_shiftreg: RTL and testbench

//   Serial-to-parallel receive buffer for the ADC121S serial interface.
//   - Samples the ADC data line (databit) on every rising clk edge, MSB first.
//   - After every WIDTH bits, latches the completed word and pulses a valid strobe.
//   - Sits between the ADC SPI pins (already synchronised to clk) and the sample FIFO / processing logic.

---
 rtl/adc_rx_pkg.sv | 12 +
 rtl/adc_rx_bitcnt.sv | 39 +++
 rtl/adc_rx_shiftreg.sv | 106 ++++++++++
 tb/tb_adc_rx_shiftreg.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/adc_rx_pkg.sv
// Shared definitions for the ADC121S serial receive path.
//   ADC_FRAME_BITS : default serial frame length (bits per conversion)
//   ADC_DATA_BITS  : default ADC payload width (LSBs of the frame)
//   adc_frame_t    : one default-width frame
package adc_rx_pkg;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS  = 12;

  typedef logic [ADC_FRAME_BITS-1:0] adc_frame_t;

endpackage

// File: rtl/adc_rx_bitcnt.sv
// Modulo-WIDTH bit counter for the ADC receive shift register.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset, clears the count
//   count out  bits received in the current frame (0..WIDTH-1)
//   wrap  out  high while count == WIDTH-1; the next edge completes a frame
import adc_rx_pkg::*;

module adc_rx_bitcnt #(
  parameter int WIDTH = ADC_FRAME_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     wrap
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    wrap    = (count_q == LAST);
    count_d = wrap ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/adc_rx_shiftreg.sv
// Serial-to-parallel receive buffer for the ADC121S serial interface.
// databit is shifted in MSB first on every rising clk edge; every WIDTH bits
// the completed word is latched into dout and dout_valid pulses for one cycle.
// Optional feature macro: ADC121_EXTRACT_EN adds the registered payload
// (sample) and a leading-zero framing check (fmt_err).
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   databit    in   serial data bit (already synchronised to clk)
//   sreg_q     out  live shift-register contents
//   bit_cnt    out  bits received in the current frame
//   dout       out  last completed frame, held until the next one completes
//   dout_valid out  one-cycle pulse when dout updates
//   sample     out  (ADC121_EXTRACT_EN) dout[DATA_BITS-1:0]
//   fmt_err    out  (ADC121_EXTRACT_EN) upper WIDTH-DATA_BITS bits of dout non-zero
import adc_rx_pkg::*;

module adc_rx_shiftreg #(
  parameter int WIDTH     = ADC_FRAME_BITS,
  parameter int DATA_BITS = ADC_DATA_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     databit,
  output logic [WIDTH-1:0]         sreg_q,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic [WIDTH-1:0]         dout,
`ifdef ADC121_EXTRACT_EN
  output logic [DATA_BITS-1:0]     sample,
  output logic                     fmt_err,
`endif
  output logic                     dout_valid
);

  if (WIDTH < 2 || WIDTH > 64 || DATA_BITS < 1 || DATA_BITS > WIDTH) begin : g_cfg_check
    $error("adc_rx_shiftreg: illegal WIDTH/DATA_BITS combination");
  end

  logic             wrap;
  logic [WIDTH-1:0] sreg_d;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;
  logic             dout_valid_q;
  logic             dout_valid_d;

  adc_rx_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk   (clk),
    .rst   (rst),
    .count (bit_cnt),
    .wrap  (wrap)
  );

  // The captured word includes the bit sampled on this same edge, so dout is
  // loaded from the next shift-register value rather than the current one.
  always_comb begin
    sreg_d       = {sreg_q[WIDTH-2:0], databit};
    dout_d       = wrap ? sreg_d : dout_q;
    dout_valid_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      sreg_q       <= sreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

`ifdef ADC121_EXTRACT_EN
  logic [DATA_BITS-1:0] sample_q;
  logic [DATA_BITS-1:0] sample_d;
  logic                 fmt_err_q;
  logic                 fmt_err_d;

  // ADC121S frames carry leading zeros above the payload; any set bit there
  // means the frame boundary is misaligned. The shift form avoids an empty
  // slice when DATA_BITS == WIDTH.
  always_comb begin
    sample_d  = wrap ? sreg_d[DATA_BITS-1:0] : sample_q;
    fmt_err_d = wrap ? ((sreg_d >> DATA_BITS) != '0) : fmt_err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q  <= '0;
      fmt_err_q <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      fmt_err_q <= fmt_err_d;
    end
  end

  assign sample  = sample_q;
  assign fmt_err = fmt_err_q;
`endif

endmodule

// File: tb/tb_adc_rx_shiftreg.sv
// Directed self-checking bench for adc_rx_shiftreg (default WIDTH=16,
// DATA_BITS=12). Builds with or without ADC121_EXTRACT_EN.
import adc_rx_pkg::*;

module tb_adc_rx_shiftreg;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic        databit;
  adc_frame_t  sreg_q;
  logic [3:0]  bit_cnt;
  adc_frame_t  dout;
  logic        dout_valid;
`ifdef ADC121_EXTRACT_EN
  logic [11:0] sample;
  logic        fmt_err;
`endif

  int checks   = 0;
  int failures = 0;

  adc_rx_shiftreg dut (
    .clk        (clk),
    .rst        (rst),
    .databit    (databit),
    .sreg_q     (sreg_q),
    .bit_cnt    (bit_cnt),
    .dout       (dout),
`ifdef ADC121_EXTRACT_EN
    .sample     (sample),
    .fmt_err    (fmt_err),
`endif
    .dout_valid (dout_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = clk_en ? ~clk : clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit well away from the edge, then sample 1 time unit after it.
  task automatic shift_bit(input logic b);
    databit = b;
    @(posedge clk);
    #1;
  endtask

  // Send one 16-bit frame MSB first on an aligned stream and check framing.
  task automatic send_frame(input adc_frame_t w, input string tag);
    for (int i = 15; i >= 0; i--) begin
      shift_bit(w[i]);
      if (i != 0) chk({tag, "_novalid"}, dout_valid, 1'b0);
    end
    chk({tag, "_valid"}, dout_valid, 1'b1);
    chk({tag, "_dout"}, dout, w);
    chk({tag, "_cnt"}, bit_cnt, 4'd0);
  endtask

  adc_frame_t w;

  initial begin
    clk_en  = 1'b0;
    rst     = 1'b0;
    databit = 1'b0;

    // 1: asynchronous reset with the clock stopped
    #3 rst = 1'b1;
    #1;
    chk("rst_sreg", sreg_q, 16'h0000);
    chk("rst_cnt", bit_cnt, 4'd0);
    chk("rst_dout", dout, 16'h0000);
    chk("rst_valid", dout_valid, 1'b0);
`ifdef ADC121_EXTRACT_EN
    chk("rst_sample", sample, 12'h000);
    chk("rst_fmt", fmt_err, 1'b0);
`endif
    clk_en = 1'b1;
    databit = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_sreg", sreg_q, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // 2: single 1 on the first edge
    shift_bit(1'b1);
    chk("t2_sreg_e1", sreg_q, 16'h0001);
    chk("t2_cnt_e1", bit_cnt, 4'd1);
    for (int i = 2; i <= 16; i++) begin
      shift_bit(1'b0);
      if (i != 16) chk("t2_novalid", dout_valid, 1'b0);
    end
    chk("t2_valid", dout_valid, 1'b1);
    chk("t2_dout", dout, 16'h8000);
    chk("t2_cnt", bit_cnt, 4'd0);
`ifdef ADC121_EXTRACT_EN
    chk("t2_sample", sample, 12'h000);
    chk("t2_fmt", fmt_err, 1'b1);
`endif

    // 3: single 1 on the fourth edge
    for (int i = 1; i <= 16; i++) begin
      shift_bit(i == 4);
      if (i == 1) chk("t3_valid_drop", dout_valid, 1'b0);
      if (i == 1) chk("t3_dout_hold", dout, 16'h8000);
      if (i == 4) chk("t3_sreg_e4", sreg_q, 16'h0001);
      if (i == 7) chk("t3_sreg_e7", sreg_q, 16'h0008);
    end
    chk("t3_valid", dout_valid, 1'b1);
    chk("t3_dout", dout, 16'h1000);

    // 4: back-to-back frames
    send_frame(16'h0ABC, "t4a");
`ifdef ADC121_EXTRACT_EN
    chk("t4a_sample", sample, 12'hABC);
    chk("t4a_fmt", fmt_err, 1'b0);
`endif
    send_frame(16'hF123, "t4b");
`ifdef ADC121_EXTRACT_EN
    chk("t4b_sample", sample, 12'h123);
    chk("t4b_fmt", fmt_err, 1'b1);
`endif

    // 5: partial frame discarded by a mid-frame reset
    for (int i = 0; i < 7; i++) begin
      shift_bit(1'b1);
      chk("t5_partial_novalid", dout_valid, 1'b0);
    end
    chk("t5_cnt_pre", bit_cnt, 4'd7);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_cnt", bit_cnt, 4'd0);
    chk("t5_rst_sreg", sreg_q, 16'h0000);
    chk("t5_rst_dout", dout, 16'h0000);
    chk("t5_rst_valid", dout_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(16'h5A5A, "t5");

    // 6: continuous random frames
    for (int f = 0; f < 100; f++) begin
      w = adc_frame_t'($urandom);
      send_frame(w, "t6");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
